// File: rtl/camera_pkg.sv
// camera_pkg: shared constants, types and helpers for the camera capture front-end.
package camera_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned PIX_W  = 16;
  localparam int unsigned CNT_W  = 10;
  localparam int unsigned SKIP_W = 4;
  localparam int unsigned ST_W   = 2;

  // Capture FSM encoding
  localparam logic [ST_W-1:0] ST_WAIT_VS = 2'd0;
  localparam logic [ST_W-1:0] ST_IDLE    = 2'd1;
  localparam logic [ST_W-1:0] ST_HI      = 2'd2;
  localparam logic [ST_W-1:0] ST_LO      = 2'd3;

  // RGB565 field widths and bit positions
  localparam int unsigned R_W   = 5;
  localparam int unsigned G_W   = 6;
  localparam int unsigned B_W   = 5;
  localparam int unsigned R_MSB = 15;
  localparam int unsigned R_LSB = 11;
  localparam int unsigned G_MSB = 10;
  localparam int unsigned G_LSB = 5;
  localparam int unsigned B_MSB = 4;
  localparam int unsigned B_LSB = 0;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } rgb565_t;

  // Vertical colour bars, left to right
  localparam rgb565_t BAR_WHITE   = '{r: 5'h1F, g: 6'h3F, b: 5'h1F};
  localparam rgb565_t BAR_YELLOW  = '{r: 5'h1F, g: 6'h3F, b: 5'h00};
  localparam rgb565_t BAR_CYAN    = '{r: 5'h00, g: 6'h3F, b: 5'h1F};
  localparam rgb565_t BAR_GREEN   = '{r: 5'h00, g: 6'h3F, b: 5'h00};
  localparam rgb565_t BAR_MAGENTA = '{r: 5'h1F, g: 6'h00, b: 5'h1F};
  localparam rgb565_t BAR_RED     = '{r: 5'h1F, g: 6'h00, b: 5'h00};
  localparam rgb565_t BAR_BLUE    = '{r: 5'h00, g: 6'h00, b: 5'h1F};
  localparam rgb565_t BAR_BLACK   = '{r: 5'h00, g: 6'h00, b: 5'h00};

  // Colour of bar idx (0 = leftmost)
  function automatic rgb565_t bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

  // Position counters stop at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/camera_capture_if.sv
// camera_capture_if: camera byte stream in, RGB565 pixel stream and status out.
interface camera_capture_if;
  import camera_pkg::*;

  logic              cam_vsync;
  logic              cam_href;
  logic [BYTE_W-1:0] cam_data;
  rgb565_t           pixel_out;
  logic              data_valid_out;
  logic [CNT_W-1:0]  pix_x;
  logic [CNT_W-1:0]  pix_y;
  logic              frame_start;
  logic              frame_done;
  logic              err_sticky;

  // Camera/consumer side
  modport master (
    output cam_vsync, cam_href, cam_data,
    input  pixel_out, data_valid_out, pix_x, pix_y, frame_start, frame_done, err_sticky
  );

  // Capture block side
  modport slave (
    input  cam_vsync, cam_href, cam_data,
    output pixel_out, data_valid_out, pix_x, pix_y, frame_start, frame_done, err_sticky
  );
endinterface

// File: rtl/cam_sync_detect.sv
// cam_sync_detect: stage-0 input register with vsync/href edge detection.
// Edge flags are registered in the same cycle as the registered level, so they
// line up with data_q and hr_level.
module cam_sync_detect
  import camera_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic              href,
  input  logic [BYTE_W-1:0] data,
  output logic              vs_rise,
  output logic              vs_fall,
  output logic              hr_rise,
  output logic              hr_fall,
  output logic              hr_level,
  output logic [BYTE_W-1:0] data_q
);

  logic vs_q;

  // Register inputs and compare the new sample with the previous registered copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q     <= 1'b0;
      vs_rise  <= 1'b0;
      vs_fall  <= 1'b0;
      hr_level <= 1'b0;
      hr_rise  <= 1'b0;
      hr_fall  <= 1'b0;
      data_q   <= '0;
    end else begin
      vs_rise  <= vsync & ~vs_q;
      vs_fall  <= ~vsync & vs_q;
      vs_q     <= vsync;
      hr_rise  <= href & ~hr_level;
      hr_fall  <= ~href & hr_level;
      hr_level <= href;
      data_q   <= data;
    end
  end

endmodule

// File: rtl/camera_capture.sv
// camera_capture: camera VSYNC/HREF/byte stream to RGB565 pixels with x/y position,
// settling-frame skip and line-format error flag.
// Optional CAM_TEST_PATTERN_EN adds test_mode, which swaps pixel data for 8 colour bars.
module camera_capture
  import camera_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned SKIP_FRAMES = 2
) (
  input  logic clk,
  input  logic rst_n,
`ifdef CAM_TEST_PATTERN_EN
  input  logic test_mode,
`endif
  camera_capture_if.slave cam
);

  localparam logic [CNT_W-1:0]  H_LIM     = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0]  V_LIM     = CNT_W'(V_ACTIVE);
  localparam logic [SKIP_W-1:0] SKIP_INIT = SKIP_W'(SKIP_FRAMES);

  logic              vs_rise, vs_fall, hr_rise, hr_fall, hr_level;
  logic [BYTE_W-1:0] data_q;

  logic [ST_W-1:0]   state, state_nxt;
  logic [SKIP_W-1:0] skip_cnt, skip_nxt;
  logic [CNT_W-1:0]  x_cnt, x_nxt;
  logic [CNT_W-1:0]  y_cnt, y_nxt;
  logic [BYTE_W-1:0] hi_byte, hi_nxt;
  logic              delivered, delivered_nxt;
  logic              pix_fire_c;
  logic              fd_set_c;
  logic              err_set_c;
  logic              in_window_c;
  rgb565_t           pixel_c;

  cam_sync_detect u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .vsync    (cam.cam_vsync),
    .href     (cam.cam_href),
    .data     (cam.cam_data),
    .vs_rise  (vs_rise),
    .vs_fall  (vs_fall),
    .hr_rise  (hr_rise),
    .hr_fall  (hr_fall),
    .hr_level (hr_level),
    .data_q   (data_q)
  );

  assign in_window_c = (x_cnt < H_LIM) && (y_cnt < V_LIM);

  // Pixel source: camera bytes, or colour bars keyed on column when in test mode
  always_comb begin
    pixel_c = rgb565_t'({hi_byte, data_q});
`ifdef CAM_TEST_PATTERN_EN
    if (test_mode) begin
      pixel_c = bar_color(x_cnt[CNT_W-1:CNT_W-3]);
    end
`endif
  end

  // Next-state logic: frame/line tracking, byte pairing, position and error events
  always_comb begin
    state_nxt     = state;
    skip_nxt      = skip_cnt;
    x_nxt         = x_cnt;
    y_nxt         = y_cnt;
    hi_nxt        = hi_byte;
    delivered_nxt = delivered;
    pix_fire_c    = 1'b0;
    fd_set_c      = 1'b0;
    err_set_c     = 1'b0;
    if (state == ST_WAIT_VS) begin
      if (vs_fall) begin
        if (skip_cnt != '0) begin
          skip_nxt = skip_cnt - SKIP_W'(1);
        end else begin
          state_nxt     = ST_IDLE;
          y_nxt         = '0;
          delivered_nxt = 1'b0;
        end
      end
    end else if (vs_rise) begin
      // Frame ends early or normally; any half-built pixel is dropped
      state_nxt = ST_WAIT_VS;
      fd_set_c  = delivered;
      err_set_c = hr_level;
    end else begin
      case (state)
        ST_IDLE: begin
          // The byte arriving with the href edge is already the high byte
          if (hr_rise) begin
            x_nxt     = '0;
            hi_nxt    = data_q;
            state_nxt = ST_LO;
          end
        end
        ST_HI: begin
          if (hr_fall) begin
            state_nxt = ST_IDLE;
            y_nxt     = sat_inc(y_cnt);
          end else begin
            hi_nxt    = data_q;
            state_nxt = ST_LO;
          end
        end
        ST_LO: begin
          if (hr_fall) begin
            state_nxt = ST_IDLE;
            y_nxt     = sat_inc(y_cnt);
            err_set_c = 1'b1;
          end else begin
            state_nxt = ST_HI;
            x_nxt     = sat_inc(x_cnt);
            if (in_window_c) begin
              pix_fire_c    = 1'b1;
              delivered_nxt = 1'b1;
            end else begin
              err_set_c = 1'b1;
            end
          end
        end
        default: state_nxt = ST_WAIT_VS;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_WAIT_VS;
      skip_cnt  <= SKIP_INIT;
      x_cnt     <= '0;
      y_cnt     <= '0;
      hi_byte   <= '0;
      delivered <= 1'b0;
    end else begin
      state     <= state_nxt;
      skip_cnt  <= skip_nxt;
      x_cnt     <= x_nxt;
      y_cnt     <= y_nxt;
      hi_byte   <= hi_nxt;
      delivered <= delivered_nxt;
    end
  end

  // Output registers: pixel/position update only on a delivered pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cam.pixel_out      <= '0;
      cam.data_valid_out <= 1'b0;
      cam.pix_x          <= '0;
      cam.pix_y          <= '0;
      cam.frame_start    <= 1'b0;
      cam.frame_done     <= 1'b0;
      cam.err_sticky     <= 1'b0;
    end else begin
      cam.data_valid_out <= pix_fire_c;
      cam.frame_start    <= pix_fire_c & ~delivered;
      cam.frame_done     <= fd_set_c;
      cam.err_sticky     <= cam.err_sticky | err_set_c;
      if (pix_fire_c) begin
        cam.pixel_out <= pixel_c;
        cam.pix_x     <= x_cnt;
        cam.pix_y     <= y_cnt;
      end
    end
  end

endmodule

// File: tb/tb_camera_capture.sv
// tb_camera_capture: directed checks of camera_capture (H_ACTIVE=4, V_ACTIVE=8, SKIP_FRAMES=2).
module tb_camera_capture;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  camera_capture_if cif ();

`ifdef CAM_TEST_PATTERN_EN
  logic test_mode = 1'b0;
`endif

  camera_capture #(.H_ACTIVE(4), .V_ACTIVE(8), .SKIP_FRAMES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef CAM_TEST_PATTERN_EN
    .test_mode (test_mode),
`endif
    .cam       (cif)
  );

`ifdef CAM_TEST_PATTERN_EN
  // Full-width instance fed the same stream, used for the colour-bar columns
  camera_capture_if cif2 ();
  assign cif2.cam_vsync = cif.cam_vsync;
  assign cif2.cam_href  = cif.cam_href;
  assign cif2.cam_data  = cif.cam_data;
  camera_capture dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .test_mode (test_mode),
    .cam       (cif2)
  );
  logic [15:0] tp_x0   = 16'h1234;
  logic [15:0] tp_x128 = 16'h1234;
  always @(negedge clk) begin
    if (test_mode && cif2.data_valid_out === 1'b1) begin
      if (cif2.pix_x == 10'd0)   tp_x0   <= 16'(cif2.pixel_out);
      if (cif2.pix_x == 10'd128) tp_x128 <= 16'(cif2.pixel_out);
    end
  end
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;

  logic [15:0] s_pix[$];
  int unsigned s_x[$];
  int unsigned s_y[$];
  int unsigned s_cyc[$];
  logic        s_fs[$];
  int unsigned lo_cyc[$];
  logic [7:0]  txq[$];
  int unsigned fd_cnt = 0;
  int unsigned fs_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe and pulse log, sampled on the falling edge
  always @(negedge clk) begin
    if (cif.data_valid_out === 1'b1) begin
      s_pix.push_back(16'(cif.pixel_out));
      s_x.push_back(32'(cif.pix_x));
      s_y.push_back(32'(cif.pix_y));
      s_fs.push_back(cif.frame_start);
      s_cyc.push_back(cyc);
    end
    if (cif.frame_done === 1'b1)  fd_cnt <= fd_cnt + 1;
    if (cif.frame_start === 1'b1) fs_cnt <= fs_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_pixel"}, 32'(cif.pixel_out), 32'd0);
    chk({tag, "_valid"}, 32'(cif.data_valid_out), 32'd0);
    chk({tag, "_x"},     32'(cif.pix_x), 32'd0);
    chk({tag, "_y"},     32'(cif.pix_y), 32'd0);
    chk({tag, "_fs"},    32'(cif.frame_start), 32'd0);
    chk({tag, "_fd"},    32'(cif.frame_done), 32'd0);
    chk({tag, "_err"},   32'(cif.err_sticky), 32'd0);
  endtask

  task automatic chk_strobe(input string tag, input int unsigned idx, input logic [15:0] pix,
                            input int unsigned x, input int unsigned y, input logic fs);
    chk({tag, "_present"}, 32'(idx < s_pix.size()), 32'd1);
    if (idx < s_pix.size()) begin
      chk({tag, "_pix"}, 32'(s_pix[idx]), 32'(pix));
      chk({tag, "_x"},   s_x[idx], x);
      chk({tag, "_y"},   s_y[idx], y);
      chk({tag, "_fs"},  32'(s_fs[idx]), 32'(fs));
    end
  endtask

  task automatic chk_lat(input string tag, input int unsigned sidx, input int unsigned lidx);
    if (sidx < s_cyc.size() && lidx < lo_cyc.size())
      chk({tag, "_lat"}, s_cyc[sidx] - lo_cyc[lidx], 32'd2);
    else
      chk({tag, "_lat_present"}, 32'd0, 32'd1);
  endtask

  task automatic vs_pulse();
    @(negedge clk);
    cif.cam_vsync = 1'b1;
    cif.cam_href  = 1'b0;
    repeat (3) @(negedge clk);
    cif.cam_vsync = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Send everything in txq as one href-high line, then a 4-cycle gap
  task automatic send_line();
    int k = 0;
    while (txq.size() > 0) begin
      @(negedge clk);
      cif.cam_href = 1'b1;
      cif.cam_data = txq.pop_front();
      if (k % 2 == 1) lo_cyc.push_back(cyc);
      k++;
    end
    @(negedge clk);
    cif.cam_href = 1'b0;
    cif.cam_data = 8'h00;
    repeat (4) @(negedge clk);
  endtask

  // Frame of nl lines x np pixels; byte k of line l is 16*l + k
  task automatic send_frame(input int nl, input int np);
    for (int l = 0; l < nl; l++) begin
      for (int k = 0; k < 2 * np; k++) txq.push_back(8'(16 * l + k));
      send_line();
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero_outputs(tag);
    rst_n = 1'b1;
  endtask

  int unsigned sb, lb, fdb, fsb;

  initial begin
    cif.cam_vsync = 1'b0;
    cif.cam_href  = 1'b0;
    cif.cam_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk_zero_outputs("rst");
    rst_n = 1'b1;

    // Two settling frames produce nothing; the third is delivered in full
    vs_pulse(); send_frame(4, 4);
    vs_pulse(); send_frame(4, 4);
    chk("skip_no_strobe", s_pix.size(), 32'd0);
    sb = s_pix.size(); lb = lo_cyc.size(); fdb = fd_cnt; fsb = fs_cnt;
    vs_pulse(); send_frame(4, 4);
    vs_pulse();
    chk("f3_count", s_pix.size() - sb, 32'd16);
    chk("f3_frame_done", fd_cnt - fdb, 32'd1);
    chk("f3_frame_start", fs_cnt - fsb, 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk_strobe($sformatf("f3_%0d", i), sb + i,
                 {8'(16 * (i / 4) + 2 * (i % 4)), 8'(16 * (i / 4) + 2 * (i % 4) + 1)},
                 i % 4, i / 4, i == 0);
      chk_lat($sformatf("f3_%0d", i), sb + i, lb + i);
    end
    chk("f3_err", 32'(cif.err_sticky), 32'd0);

    // RGB565 assembly, odd-length line, following line
    sb = s_pix.size(); lb = lo_cyc.size(); fdb = fd_cnt;
    txq = '{8'hF8, 8'h00, 8'h07, 8'hE0};
    send_line();
    chk_strobe("red", sb, 16'hF800, 0, 0, 1'b1);
    chk_lat("red", sb, lb);
    chk_strobe("green", sb + 1, 16'h07E0, 1, 0, 1'b0);
    chk_lat("green", sb + 1, lb + 1);
    chk("pair_err", 32'(cif.err_sticky), 32'd0);
    txq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_line();
    chk("odd_count", s_pix.size() - sb, 32'd4);
    chk_strobe("odd0", sb + 2, 16'h1122, 0, 1, 1'b0);
    chk_strobe("odd1", sb + 3, 16'h3344, 1, 1, 1'b0);
    chk("odd_err", 32'(cif.err_sticky), 32'd1);
    txq = '{8'hAA, 8'hBB};
    send_line();
    chk_strobe("next_line", sb + 4, 16'hAABB, 0, 2, 1'b0);
    chk("hold_x", 32'(cif.pix_x), 32'd0);
    chk("hold_y", 32'(cif.pix_y), 32'd2);
    vs_pulse();
    chk("f4_frame_done", fd_cnt - fdb, 32'd1);

    // Line longer than H_ACTIVE
    do_reset("rst_d");
    vs_pulse(); vs_pulse(); vs_pulse();
    sb = s_pix.size();
    for (int k = 0; k < 12; k++) txq.push_back(8'(8'h40 + k));
    send_line();
    chk("wide_count", s_pix.size() - sb, 32'd4);
    for (int i = 0; i < 4; i++)
      chk_strobe($sformatf("wide_%0d", i), sb + i,
                 {8'(8'h40 + 2 * i), 8'(8'h41 + 2 * i)}, i, 0, i == 0);
    chk("wide_err", 32'(cif.err_sticky), 32'd1);
    chk("wide_hold_x", 32'(cif.pix_x), 32'd3);

    // Reset in the middle of a line, then bytes with no vsync: no strobes
    @(negedge clk); cif.cam_href = 1'b1; cif.cam_data = 8'h12;
    @(negedge clk); cif.cam_data = 8'h34;
    @(negedge clk); cif.cam_data = 8'h56; rst_n = 1'b0;
    @(negedge clk); cif.cam_data = 8'h78;
    chk_zero_outputs("rst_mid");
    rst_n = 1'b1;
    sb = s_pix.size();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); cif.cam_data = 8'(8'h80 + k);
    end
    @(negedge clk); cif.cam_href = 1'b0;
    repeat (4) @(negedge clk);
    txq = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_line();
    chk("rst_mid_no_strobe", s_pix.size() - sb, 32'd0);

    // Vsync arriving mid-line with href high
    vs_pulse(); vs_pulse(); vs_pulse();
    sb = s_pix.size(); fdb = fd_cnt; fsb = fs_cnt;
    send_frame(1, 4);
    chk("pre_vs_err", 32'(cif.err_sticky), 32'd0);
    @(negedge clk); cif.cam_href = 1'b1; cif.cam_data = 8'hA0;
    @(negedge clk); cif.cam_data = 8'hA1;
    @(negedge clk); cif.cam_data = 8'hA2;
    @(negedge clk); cif.cam_vsync = 1'b1; cif.cam_data = 8'hA3;
    @(negedge clk); cif.cam_href = 1'b0;
    repeat (3) @(negedge clk);
    cif.cam_vsync = 1'b0;
    repeat (4) @(negedge clk);
    chk("vs_mid_count", s_pix.size() - sb, 32'd5);
    chk_strobe("vs_mid_last", sb + 4, 16'hA0A1, 0, 1, 1'b0);
    chk("vs_mid_frame_done", fd_cnt - fdb, 32'd1);
    chk("vs_mid_err", 32'(cif.err_sticky), 32'd1);
    txq = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    send_line();
    chk_strobe("restart0", sb + 5, 16'hB0B1, 0, 0, 1'b1);
    chk_strobe("restart1", sb + 6, 16'hB2B3, 1, 0, 1'b0);
    chk("restart_frame_start", fs_cnt - fsb, 32'd2);
    chk("restart_frame_done", fd_cnt - fdb, 32'd1);

`ifdef CAM_TEST_PATTERN_EN
    // Colour bars replace camera data on the full-width instance
    test_mode = 1'b1;
    for (int k = 0; k < 258; k++) txq.push_back(8'h5A);
    send_line();
    chk("bar_x0", 32'(tp_x0), 32'h0000FFFF);
    chk("bar_x128", 32'(tp_x128), 32'h0000FFE0);
    test_mode = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
